// File: rtl/reaction_game_pkg.sv
// Shared types and constants for the reaction-game round controller.
package reaction_game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    GO        = 2'd2,
    WON       = 2'd3
  } rg_state_e;

  localparam int unsigned CNT_W     = 17;
  localparam int unsigned LFSR_W    = 16;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned score_width(input int unsigned win_score);
    return (win_score < 1) ? 1 : $clog2(win_score + 1);
  endfunction

  function automatic int unsigned pid_width(input int unsigned num_players);
    return (num_players < 2) ? 1 : $clog2(num_players);
  endfunction

endpackage

// File: rtl/rg_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; steps every clock, reseeds if it ever reads zero.
module rg_lfsr16
  import reaction_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (r_lfsr == '0) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// N-player reaction-game round controller: random countdown, false-start penalty, first-reactor scoring.
// Optional reaction-time capture enabled by defining REACTION_GAME_REACT_TIME_EN.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned MIN_WAIT_MS   = 1000,
  parameter logic [15:0] RAND_MASK     = 16'h0FFF,
  parameter int unsigned GO_TIMEOUT_MS = 3000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int unsigned SCORE_W      = score_width(WIN_SCORE),
  localparam int unsigned PID_W        = pid_width(NUM_PLAYERS)
) (
  input  logic                           cin,
  input  logic                           reset_n,
  input  logic                           tick_ms,
  input  logic                           start,
  input  logic                           clear_scores,
  input  logic [NUM_PLAYERS-1:0]         sw,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         score_change,
  output logic                           winner_valid,
  output logic [PID_W-1:0]               winner_id,
  output logic                           go,
  output logic                           in_progress
`ifdef REACTION_GAME_REACT_TIME_EN
  ,
  output logic [15:0]                    react_ms,
  output logic                           react_valid
`endif
);

  rg_state_e                r_state;
  rg_state_e                w_state_nxt;
  logic [NUM_PLAYERS-1:0]   r_sw_prev;
  logic [NUM_PLAYERS-1:0]   w_rise;
  logic                     w_any_rise;
  logic [PID_W-1:0]         w_rise_idx;
  logic [SCORE_W-1:0]       w_rise_score;
  logic [SCORE_W-1:0]       r_score [NUM_PLAYERS];
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_cnt_done;
  logic [LFSR_W-1:0]        w_lfsr;
  logic                     w_false_start;
  logic                     w_win;
  logic                     w_go_nxt;
  logic                     w_in_prog_nxt;
  logic                     w_winner_valid_nxt;

  rg_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (cin),
    .rst_n  (reset_n),
    .o_lfsr (w_lfsr)
  );

  assign w_rise     = sw & ~r_sw_prev;
  assign w_any_rise = |w_rise;
  // A phase ends on the tick that would take the counter to zero, or at once if already zero
  assign w_cnt_done = (r_cnt == '0) || (tick_ms && (r_cnt == CNT_W'(1)));

  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_prev <= '0;
    end else begin
      r_sw_prev <= sw;
    end
  end

  // Lowest-index rising player and its current score
  always_comb begin
    w_rise_idx   = '0;
    w_rise_score = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_rise_idx   = PID_W'(i);
        w_rise_score = r_score[i];
      end
    end
  end

  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_false_start = 1'b0;
    w_win         = 1'b0;
    if (clear_scores) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && (sw == '0)) w_state_nxt = COUNTDOWN;
        end
        COUNTDOWN: begin
          if (w_any_rise) begin
            w_false_start = 1'b1;
            w_state_nxt   = IDLE;
          end else if (w_cnt_done) begin
            w_state_nxt = GO;
          end
        end
        GO: begin
          if (w_any_rise) begin
            w_win       = 1'b1;
            w_state_nxt = (w_rise_score == SCORE_W'(WIN_SCORE - 1)) ? WON : IDLE;
          end else if (w_cnt_done) begin
            w_state_nxt = IDLE;
          end
        end
        WON:     w_state_nxt = WON;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_go_nxt           = (w_state_nxt == GO);
    w_in_prog_nxt      = (w_state_nxt == COUNTDOWN) || (w_state_nxt == GO);
    w_winner_valid_nxt = (w_state_nxt == WON);
  end

  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      go           <= 1'b0;
      in_progress  <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      go           <= w_go_nxt;
      in_progress  <= w_in_prog_nxt;
      winner_valid <= w_winner_valid_nxt;
      if (clear_scores) begin
        winner_id <= '0;
      end else if (w_win && (w_state_nxt == WON)) begin
        winner_id <= w_rise_idx;
      end
    end
  end

  // Countdown / GO-timeout counter
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear_scores) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_state_nxt == COUNTDOWN) begin
            r_cnt <= CNT_W'(MIN_WAIT_MS) + CNT_W'(w_lfsr & RAND_MASK);
          end
        end
        COUNTDOWN: begin
          if (w_state_nxt == GO) begin
            r_cnt <= CNT_W'(GO_TIMEOUT_MS);
          end else if (tick_ms && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GO: begin
          if (tick_ms && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Scores; a clear reports every player whose score actually dropped to zero
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      score_change <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      score_change <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (clear_scores) begin
          r_score[i]      <= '0;
          score_change[i] <= (r_score[i] != '0);
        end else if (PID_W'(i) == w_rise_idx) begin
          if (w_false_start && (r_score[i] != '0)) begin
            r_score[i]      <= r_score[i] - SCORE_W'(1);
            score_change[i] <= 1'b1;
          end else if (w_win) begin
            r_score[i]      <= r_score[i] + SCORE_W'(1);
            score_change[i] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign score[g*SCORE_W +: SCORE_W] = r_score[g];
  end

`ifdef REACTION_GAME_REACT_TIME_EN
  logic [15:0] r_react_cnt;

  // Reaction timer: restarts on GO entry, latched by the winning rise
  always_ff @(posedge cin or negedge reset_n) begin
    if (!reset_n) begin
      r_react_cnt <= '0;
      react_ms    <= '0;
      react_valid <= 1'b0;
    end else begin
      react_valid <= 1'b0;
      if (clear_scores) begin
        r_react_cnt <= '0;
        react_ms    <= '0;
      end else begin
        if ((r_state != GO) && (w_state_nxt == GO)) begin
          r_react_cnt <= '0;
        end else if ((r_state == GO) && tick_ms && (r_react_cnt != 16'hFFFF)) begin
          r_react_cnt <= r_react_cnt + 16'd1;
        end
        if (w_win) begin
          react_ms    <= r_react_cnt;
          react_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl (4 players, short countdown/timeout).
module tb_reaction_game_ctrl;

  localparam int unsigned NP    = 4;
  localparam int unsigned WIN   = 5;
  localparam int unsigned SCW   = 3;
  localparam int unsigned PIDW  = 2;

  typedef struct packed {
    logic [NP*SCW-1:0] score;
    logic [NP-1:0]     chg;
  } exp_t;

  logic                cin;
  logic                reset_n;
  logic                tick_ms;
  logic                start;
  logic                clear_scores;
  logic [NP-1:0]       sw;
  logic [NP*SCW-1:0]   score;
  logic [NP-1:0]       score_change;
  logic                winner_valid;
  logic [PIDW-1:0]     winner_id;
  logic                go;
  logic                in_progress;
`ifdef REACTION_GAME_REACT_TIME_EN
  logic [15:0]         react_ms;
  logic                react_valid;
`endif

  exp_t exp_q[$];
  int   exp_score [NP];
  int   n_total;
  int   n_pass;

  reaction_game_ctrl #(
    .NUM_PLAYERS   (NP),
    .WIN_SCORE     (WIN),
    .MIN_WAIT_MS   (4),
    .RAND_MASK     (16'h0000),
    .GO_TIMEOUT_MS (5),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .cin          (cin),
    .reset_n      (reset_n),
    .tick_ms      (tick_ms),
    .start        (start),
    .clear_scores (clear_scores),
    .sw           (sw),
    .score        (score),
    .score_change (score_change),
    .winner_valid (winner_valid),
    .winner_id    (winner_id),
    .go           (go),
    .in_progress  (in_progress)
`ifdef REACTION_GAME_REACT_TIME_EN
    ,
    .react_ms     (react_ms),
    .react_valid  (react_valid)
`endif
  );

  initial cin = 1'b0;
  always #10 cin = ~cin;

  function automatic logic [NP*SCW-1:0] pack_model();
    logic [NP*SCW-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i*SCW +: SCW] = SCW'(exp_score[i]);
    return v;
  endfunction

  task automatic push_exp(input logic [NP-1:0] chg);
    exp_t e;
    e.score = pack_model();
    e.chg   = chg;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge cin);
    #1;
  endtask

  task automatic drive_to_go();
    start = 1'b1;
    step();
    start = 1'b0;
    tick_ms = 1'b1;
    repeat (4) step();
    tick_ms = 1'b0;
  endtask

  task automatic play_round(input int p);
    exp_t e;
    drive_to_go();
    n_total++; if (go !== 1'b1) $display("FAIL round_go p=%0d act=%b exp=1", p, go); else n_pass++;
    sw[p] = 1'b1;
    exp_score[p]++;
    push_exp(NP'(1 << p));
    step();
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL round_score p=%0d act=%h exp=%h", p, score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL round_chg p=%0d act=%b exp=%b", p, score_change, e.chg); else n_pass++;
    n_total++; if (in_progress !== 1'b0) $display("FAIL round_inprog p=%0d act=%b exp=0", p, in_progress); else n_pass++;
    if (exp_score[p] == WIN) begin
      n_total++;
      if (winner_valid !== 1'b1 || winner_id !== PIDW'(p))
        $display("FAIL round_winner act=%b/%0d exp=1/%0d", winner_valid, winner_id, p);
      else n_pass++;
    end else begin
      n_total++; if (winner_valid !== 1'b0) $display("FAIL round_nowin act=%b exp=0", winner_valid); else n_pass++;
    end
    sw[p] = 1'b0;
    step();
    n_total++; if (score_change !== '0) $display("FAIL round_pulse act=%b exp=0", score_change); else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick_ms = 1'b0; start = 1'b0; clear_scores = 1'b0; sw = '0;
    for (int i = 0; i < NP; i++) exp_score[i] = 0;
    repeat (3) step();
    n_total++; if (score !== '0) $display("FAIL rst_score act=%h exp=0", score); else n_pass++;
    n_total++; if (score_change !== '0) $display("FAIL rst_chg act=%b exp=0", score_change); else n_pass++;
    n_total++; if (go !== 1'b0) $display("FAIL rst_go act=%b exp=0", go); else n_pass++;
    n_total++; if (in_progress !== 1'b0) $display("FAIL rst_inprog act=%b exp=0", in_progress); else n_pass++;
    n_total++; if (winner_valid !== 1'b0 || winner_id !== '0)
      $display("FAIL rst_winner act=%b/%0d exp=0/0", winner_valid, winner_id); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_countdown_go();
    exp_t e;
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (in_progress !== 1'b1 || go !== 1'b0)
      $display("FAIL cd_enter act=%b/%b exp=1/0", in_progress, go); else n_pass++;
    tick_ms = 1'b1;
    repeat (3) step();
    n_total++; if (go !== 1'b0) $display("FAIL cd_early_go act=%b exp=0", go); else n_pass++;
    step();
    tick_ms = 1'b0;
    n_total++; if (go !== 1'b1) $display("FAIL cd_go_after_4 act=%b exp=1", go); else n_pass++;
    tick_ms = 1'b1;
    repeat (2) step();
    tick_ms = 1'b0;
    sw[2] = 1'b1;
    exp_score[2]++;
    push_exp(4'b0100);
    step();
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL cd_score act=%h exp=%h", score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL cd_chg act=%b exp=%b", score_change, e.chg); else n_pass++;
    n_total++; if (go !== 1'b0 || in_progress !== 1'b0)
      $display("FAIL cd_idle act=%b/%b exp=0/0", go, in_progress); else n_pass++;
`ifdef REACTION_GAME_REACT_TIME_EN
    n_total++; if (react_ms !== 16'd2 || react_valid !== 1'b1)
      $display("FAIL react act=%0d/%b exp=2/1", react_ms, react_valid); else n_pass++;
`endif
    sw[2] = 1'b0;
    step();
    n_total++; if (score_change !== '0) $display("FAIL cd_pulse act=%b exp=0", score_change); else n_pass++;
  endtask

  task automatic test_false_start();
    exp_t e;
    play_round(1);
    play_round(1);
    start = 1'b1;
    step();
    start = 1'b0;
    sw[1] = 1'b1;
    exp_score[1]--;
    push_exp(4'b0010);
    step();
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL fs_score act=%h exp=%h", score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL fs_chg act=%b exp=%b", score_change, e.chg); else n_pass++;
    n_total++; if (in_progress !== 1'b0) $display("FAIL fs_inprog act=%b exp=0", in_progress); else n_pass++;
    sw[1] = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    sw[3] = 1'b1;
    push_exp(4'b0000);
    step();
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL fs0_score act=%h exp=%h", score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL fs0_chg act=%b exp=%b", score_change, e.chg); else n_pass++;
    n_total++; if (in_progress !== 1'b0) $display("FAIL fs0_inprog act=%b exp=0", in_progress); else n_pass++;
    sw[3] = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    drive_to_go();
    sw = 4'b1001;
    exp_score[0]++;
    push_exp(4'b0001);
    step();
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL sim_score act=%h exp=%h", score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL sim_chg act=%b exp=%b", score_change, e.chg); else n_pass++;
    sw = '0;
    step();
  endtask

  task automatic test_win_and_clear();
    exp_t e;
    logic [NP-1:0] clr_chg;
    repeat (3) play_round(1);
    play_round(1);
    sw[0] = 1'b1;
    step();
    n_total++; if (score !== pack_model() || score_change !== '0)
      $display("FAIL won_frozen act=%h/%b exp=%h/0", score, score_change, pack_model()); else n_pass++;
    sw[0] = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (winner_valid !== 1'b1 || winner_id !== 2'd1 || in_progress !== 1'b0)
      $display("FAIL won_start act=%b/%0d/%b exp=1/1/0", winner_valid, winner_id, in_progress); else n_pass++;
    clr_chg = '0;
    for (int i = 0; i < NP; i++) begin
      clr_chg[i] = (exp_score[i] != 0);
      exp_score[i] = 0;
    end
    clear_scores = 1'b1;
    push_exp(clr_chg);
    step();
    clear_scores = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (score !== e.score) $display("FAIL clr_score act=%h exp=%h", score, e.score); else n_pass++;
    n_total++; if (score_change !== e.chg) $display("FAIL clr_chg act=%b exp=%b", score_change, e.chg); else n_pass++;
    n_total++; if (winner_valid !== 1'b0 || winner_id !== '0 || in_progress !== 1'b0)
      $display("FAIL clr_state act=%b/%0d/%b exp=0/0/0", winner_valid, winner_id, in_progress); else n_pass++;
    clear_scores = 1'b1;
    start = 1'b1;
    step();
    clear_scores = 1'b0;
    start = 1'b0;
    n_total++; if (in_progress !== 1'b0) $display("FAIL clr_over_start act=%b exp=0", in_progress); else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    drive_to_go();
    tick_ms = 1'b1;
    repeat (4) step();
    n_total++; if (in_progress !== 1'b1 || go !== 1'b1)
      $display("FAIL to_early act=%b/%b exp=1/1", in_progress, go); else n_pass++;
    step();
    tick_ms = 1'b0;
    n_total++; if (in_progress !== 1'b0 || go !== 1'b0)
      $display("FAIL to_idle act=%b/%b exp=0/0", in_progress, go); else n_pass++;
    n_total++; if (score !== pack_model() || score_change !== '0)
      $display("FAIL to_score act=%h/%b exp=%h/0", score, score_change, pack_model()); else n_pass++;
    step();
  endtask

  task automatic test_start_blocked();
    sw[0] = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (in_progress !== 1'b0) $display("FAIL blk_start act=%b exp=0", in_progress); else n_pass++;
    sw[0] = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    play_round(3);
    play_round(2);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_countdown_go();
    test_false_start();
    test_simultaneous();
    test_win_and_clear();
    test_timeout();
    test_start_blocked();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL sb_leftover act=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Parametrised N-player reaction-game round controller. Successor to the fixed two-player score/countdown logic.
- Sits between the switch debouncer / ms tick divider and the seven-segment / Arduino output drivers.
- Runs a pseudo-random countdown, penalises false starts and rewards the first reactor after GO.
- Tracks per-player scores and declares a winner at a configurable score.

Parameters:
- NUM_PLAYERS, 2, number of player switches (2..8)
- WIN_SCORE, 5, score that ends the match
- MIN_WAIT_MS, 1000, minimum countdown length in ms
- RAND_MASK, 16'h0FFF, mask applied to LFSR value added to MIN_WAIT_MS
- GO_TIMEOUT_MS, 3000, ms in GO state before the round is abandoned
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- cin  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- tick_ms  in  1  single-cycle pulse once per ms, synchronous to cin
- start  in  1  single-cycle start-round request
- clear_scores  in  1  single-cycle match reset
- sw  in  NUM_PLAYERS  debounced player switches
- score  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
- score_change  out  NUM_PLAYERS  one-cycle pulse when the player's score changed
- winner_valid  out  1  high in WON
- winner_id  out  PID_W  winning player index, valid with winner_valid
- go  out  1  high in GO (lamp/buzzer)
- in_progress  out  1  high in COUNTDOWN or GO

Behaviour:
- Reset (async assert, sync release): state IDLE, all scores 0, all outputs 0, LFSR=LFSR_SEED, switch history regs 0.
- Edge detect: rise[i] = sw[i] & ~sw_prev[i]; sw_prev updates every cycle. Only rising edges score.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cin cycle. Never zero.
- States: IDLE, COUNTDOWN, GO, WON.
- IDLE -> COUNTDOWN on start when no sw bit is high. Loads cnt = MIN_WAIT_MS + (lfsr & RAND_MASK). If any sw is high, start is ignored.
- COUNTDOWN:
  - cnt decrements on tick_ms.
  - Any rise is a false start. The lowest-index rising player loses 1 point (saturates at 0; pulse score_change only if the value changed). Next state IDLE.
  - cnt==0 with no rise -> GO. cnt is reloaded with GO_TIMEOUT_MS.
- GO:
  - go=1.
  - First rise wins the round; simultaneous rises go to the lowest index. That player gets +1 and score_change pulses.
  - If the new score == WIN_SCORE -> WON, else IDLE.
  - cnt decrements on tick_ms; cnt==0 with no rise -> IDLE, no score change.
- WON: winner_valid=1 and winner_id held. start is ignored. Scores are frozen.
- clear_scores: in any state, the next cycle sets all scores to 0, state to IDLE and clears the winner. It overrides a simultaneous rise or start.
- Timing: all outputs are registered, with 1-cycle latency from the causing input edge.
- Score width: SCORE_W = $clog2(WIN_SCORE+1). Scores never exceed WIN_SCORE.
- Counter width: CNT_W = 17 bits; it covers MIN_WAIT_MS + RAND_MASK.
- start in COUNTDOWN/GO is ignored. tick_ms and rise in the same cycle: rise takes priority.

Optional Feature:
- Macro: REACTION_GAME_REACT_TIME_EN.
- When defined:
  - Adds port react_ms out 16 and react_valid out 1.
  - A ms counter clears on entry to GO and increments on tick_ms, saturating at 16'hFFFF.
  - On the winning rise, react_ms latches the count and react_valid pulses for 1 cycle.
  - react_ms holds until the next latch, reset, or clear_scores (cleared to 0).
- When undefined: the ports and logic are absent.

Decomposition:
- Package reaction_game_pkg: state enum (IDLE, COUNTDOWN, GO, WON), LFSR taps constant, CNT_W, score-width helper function.
- One sub-module: rg_lfsr16, holding the free-running LFSR with seed parameter.
- The rest stays in one FSM/datapath module.

Test Plan:
- Reset with NUM_PLAYERS=4 -> all scores 0, go=0, in_progress=0, winner_valid=0.
- MIN_WAIT_MS=4, RAND_MASK=0, start, then 4 tick_ms, then sw[2] rises -> go high after the 4th tick; score[2]=1; score_change=4'b0100 for 1 cycle; state IDLE.
- Player 1 at score 2, sw[1] rises during COUNTDOWN -> score[1]=1 and in_progress=0. Repeat from score 0 -> stays 0 with no score_change pulse.
- sw[0] and sw[3] rise in the same cycle in GO -> only player 0 is credited.
- Player 1 at WIN_SCORE-1 wins a round -> winner_valid=1, winner_id=1. A following start is ignored; clear_scores -> all 0, IDLE.
- GO_TIMEOUT_MS=5 with no switch -> IDLE after 5 ticks, scores unchanged. Start while sw[0] held high -> stays IDLE.
